// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC bus master: state encoding, counter width,
// RTC register map and the per-state output bundle.
package rtc_bus_ctrl_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  localparam logic [7:0] REG_SEG      = 8'h21;
  localparam logic [7:0] REG_MIN      = 8'h22;
  localparam logic [7:0] REG_HR       = 8'h23;
  localparam logic [7:0] REG_DATE     = 8'h24;
  localparam logic [7:0] REG_MES      = 8'h25;
  localparam logic [7:0] REG_ANO      = 8'h26;
  localparam logic [7:0] REG_DIA_SEM  = 8'h27;
  localparam logic [7:0] REG_NUM_SEM  = 8'h28;
  localparam logic [7:0] REG_TIMER_S  = 8'h41;
  localparam logic [7:0] REG_TIMER_M  = 8'h42;
  localparam logic [7:0] REG_TIMER_H  = 8'h43;
  localparam logic [7:0] REG_TRANSFER = 8'hF0;

  // Pin levels for one state; strobes and chip select are active low.
  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic aod;
    logic bus_oe;
    logic busy;
  } pins_t;

  function automatic logic is_addr_phase(input state_t st);
    return (st == ST_A_SETUP) || (st == ST_A_STROBE) || (st == ST_A_HOLD);
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter timing each bus phase; tc flags the last cycle of a phase.
module rtc_phase_timer
  import rtc_bus_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == CNT_ZERO);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus master for a V3023-style RTC: one address write, an idle gap, then one
// data read or write on the multiplexed DATA_ADDRESS bus.
module rtc_bus_ctrl
  import rtc_bus_ctrl_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done,
  inout  wire  [7:0] DATA_ADDRESS,
  output logic       ChipSelect,
  output logic       Read,
  output logic       Write,
  output logic       AoD
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(T_GAP - 1);

  state_t           state_r;
  state_t           state_s;
  state_t           nxt_s;
  logic [CNT_W-1:0] dur_m1_s;
  logic             go_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             tc_s;
  logic             rw_r;
  logic [7:0]       addr_r;
  logic [7:0]       wdata_r;
  logic [7:0]       bus_s;
  logic [7:0]       bus_out_r;
  logic             bus_oe_r;
  pins_t            pins_s;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  // Successor state and its length; IDLE advances on start, others on terminal count.
  always_comb begin
    nxt_s    = ST_IDLE;
    dur_m1_s = CNT_ZERO;
    go_s     = tc_s;
    case (state_r)
      ST_IDLE:     begin nxt_s = ST_A_SETUP;  dur_m1_s = SETUP_M1; go_s = start; end
      ST_A_SETUP:  begin nxt_s = ST_A_STROBE; dur_m1_s = PULSE_M1; end
      ST_A_STROBE: begin nxt_s = ST_A_HOLD;   dur_m1_s = HOLD_M1;  end
      ST_A_HOLD:   begin nxt_s = ST_GAP;      dur_m1_s = GAP_M1;   end
      ST_GAP:      begin nxt_s = ST_D_SETUP;  dur_m1_s = SETUP_M1; end
      ST_D_SETUP:  begin nxt_s = ST_D_STROBE; dur_m1_s = PULSE_M1; end
      ST_D_STROBE: begin nxt_s = ST_D_HOLD;   dur_m1_s = HOLD_M1;  end
      ST_D_HOLD:   begin nxt_s = ST_DONE;     dur_m1_s = CNT_ZERO; end
      ST_DONE:     begin nxt_s = ST_IDLE;     go_s = 1'b1;         end
      default:     begin nxt_s = ST_IDLE;     go_s = 1'b1;         end
    endcase
    if (go_s) begin
      state_s    = nxt_s;
      load_s     = 1'b1;
      load_val_s = dur_m1_s;
    end else begin
      state_s    = state_r;
      load_s     = 1'b0;
      load_val_s = CNT_ZERO;
    end
  end

  // Pin levels for the state being entered, so registered pins line up with it.
  always_comb begin
    pins_s = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, aod: 1'b1, bus_oe: 1'b0, busy: 1'b1};
    case (state_s)
      ST_IDLE:     pins_s.busy = 1'b0;
      ST_A_SETUP,
      ST_A_HOLD:   begin pins_s.cs_n = 1'b0; pins_s.aod = 1'b0; pins_s.bus_oe = 1'b1; end
      ST_A_STROBE: begin
        pins_s.cs_n = 1'b0; pins_s.aod = 1'b0; pins_s.bus_oe = 1'b1; pins_s.wr_n = 1'b0;
      end
      ST_D_SETUP,
      ST_D_HOLD:   begin pins_s.cs_n = 1'b0; pins_s.bus_oe = ~rw_r; end
      ST_D_STROBE: begin
        pins_s.cs_n = 1'b0; pins_s.bus_oe = ~rw_r; pins_s.wr_n = rw_r; pins_s.rd_n = ~rw_r;
      end
      ST_GAP:      pins_s.busy = 1'b1;
      ST_DONE:     pins_s.busy = 1'b1;
      default:     pins_s.busy = 1'b1;
    endcase
    // addr_r is loaded on the same edge that enters A_SETUP, so bypass it there.
    if (is_addr_phase(state_s)) begin
      bus_s = (state_r == ST_IDLE) ? addr : addr_r;
    end else begin
      bus_s = wdata_r;
    end
  end

  // Request capture; only accepted while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && start) begin
      rw_r    <= rw;
      addr_r  <= addr;
      wdata_r <= wdata;
    end else begin
      rw_r    <= rw_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ChipSelect  <= 1'b1;
      Read        <= 1'b1;
      Write       <= 1'b1;
      AoD         <= 1'b1;
      bus_oe_r    <= 1'b0;
      bus_out_r   <= 8'h00;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      state_r     <= state_s;
      ChipSelect  <= pins_s.cs_n;
      Read        <= pins_s.rd_n;
      Write       <= pins_s.wr_n;
      AoD         <= pins_s.aod;
      bus_oe_r    <= pins_s.bus_oe;
      bus_out_r   <= bus_s;
      busy        <= pins_s.busy;
      done        <= (state_s == ST_DONE);
      rdata_valid <= (state_s == ST_DONE) && rw_r;
    end
  end

  // Read data is latched on the edge that closes the read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else if ((state_r == ST_D_STROBE) && tc_s && rw_r) begin
      rdata <= DATA_ADDRESS;
    end else begin
      rdata <= rdata;
    end
  end

  assign DATA_ADDRESS = bus_oe_r ? bus_out_r : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Self-checking bench for rtc_bus_ctrl: table-driven transactions with a
// per-cycle pin check, a done/rdata scoreboard, and multi-cycle corner cases.
module tb_rtc_bus_ctrl;
  import rtc_bus_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, rw;
  logic [7:0] addr, wdata, rdata, rtc_val;
  logic       rdata_valid, busy, done, cs_n, rd_n, wr_n, aod;
  wire  [7:0] data_address;

  logic       start1;
  logic [7:0] rdata1;
  logic       rdata_valid1, busy1, done1, cs1_n, rd1_n, wr1_n, aod1;
  wire  [7:0] data_address1;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .DATA_ADDRESS(data_address), .ChipSelect(cs_n), .Read(rd_n), .Write(wr_n), .AoD(aod)
  );

  rtc_bus_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(1'b0), .addr(8'h42), .wdata(8'h9C),
    .rdata(rdata1), .rdata_valid(rdata_valid1), .busy(busy1), .done(done1),
    .DATA_ADDRESS(data_address1), .ChipSelect(cs1_n), .Read(rd1_n), .Write(wr1_n), .AoD(aod1)
  );

  // RTC model: drives the bus only while the read strobe is low.
  assign data_address = (!rd_n) ? rtc_val : 8'bzzzz_zzzz;

  typedef struct {
    logic       rdata;
    logic [7:0] val;
  } unused_t;

  typedef struct {
    logic [7:0] rdata;
    logic       valid;
  } exp_t;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rtc;
    logic [7:0] exp_rdata;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[5];
  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Protocol watch and scoreboard pop on every done.
  always @(negedge clk) begin
    if (mon_en) begin
      check("no_rd_wr_overlap_or_drive_on_read",
            {31'd0, (!rd_n && !wr_n) || (!rd_n && dut.bus_oe_r)}, 32'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_rdata", {24'd0, rdata}, {24'd0, e.rdata});
          check("sb_rdata_valid", {31'd0, rdata_valid}, {31'd0, e.valid});
        end
      end else begin
        check("valid_without_done", {31'd0, rdata_valid}, 32'd0);
      end
    end
  end

  // One default-timing transaction, checking pins every cycle from 1 to 22.
  task automatic run_txn(input vec_t v);
    logic       ap, dp, exp_oe;
    logic [6:0] exp_pins;
    @(negedge clk);
    rw = v.rw; addr = v.addr; wdata = v.wdata; rtc_val = v.rtc; start = 1'b1;
    sb_q.push_back('{rdata: v.exp_rdata, valid: v.rw});
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = 1'b0;
      ap = (k <= 8);
      dp = (k >= 13) && (k <= 20);
      exp_oe = ap || (dp && !v.rw);
      exp_pins = {(ap || dp) ? 1'b0 : 1'b1,
                  (v.rw && k >= 15 && k <= 18) ? 1'b0 : 1'b1,
                  ((k >= 3 && k <= 6) || (!v.rw && k >= 15 && k <= 18)) ? 1'b0 : 1'b1,
                  ap ? 1'b0 : 1'b1,
                  exp_oe, (k <= 21), (k == 21)};
      check($sformatf("pins a%h c%0d {cs,rd,wr,aod,oe,busy,done}", v.addr, k),
            {25'd0, cs_n, rd_n, wr_n, aod, dut.bus_oe_r, busy, done}, {25'd0, exp_pins});
      if (exp_oe) begin
        check($sformatf("bus a%h c%0d", v.addr, k), {24'd0, data_address},
              {24'd0, ap ? v.addr : v.wdata});
      end
    end
  endtask

  initial begin
    tbl[0] = '{rw: 1'b0, addr: REG_SEG,      wdata: 8'h45, rtc: 8'hEE, exp_rdata: 8'h00};
    tbl[1] = '{rw: 1'b1, addr: REG_HR,       wdata: 8'h00, rtc: 8'h12, exp_rdata: 8'h12};
    tbl[2] = '{rw: 1'b0, addr: REG_TRANSFER, wdata: 8'hA5, rtc: 8'h66, exp_rdata: 8'h12};
    tbl[3] = '{rw: 1'b1, addr: REG_TIMER_S,  wdata: 8'hFF, rtc: 8'hC3, exp_rdata: 8'hC3};
    tbl[4] = '{rw: 1'b1, addr: REG_NUM_SEM,  wdata: 8'h11, rtc: 8'h00, exp_rdata: 8'h00};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; rw = 1'b0;
    addr = 8'h00; wdata = 8'h00; rtc_val = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_pins {cs,rd,wr,aod,oe,busy,done,valid}",
          {24'd0, cs_n, rd_n, wr_n, aod, dut.bus_oe_r, busy, done, rdata_valid}, 32'h0000_00F0);
    check("reset_rdata", {24'd0, rdata}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Start pulses while busy are dropped.
    @(negedge clk);
    rw = 1'b0; addr = REG_MIN; wdata = 8'h33; start = 1'b1;
    sb_q.push_back('{rdata: 8'h00, valid: 1'b0});
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = (k == 5) || (k == 20);
      if (k == 21) check("ignored_start_done21", {31'd0, done}, 32'd1);
      if (k >= 22) check($sformatf("ignored_start_busy c%0d", k), {31'd0, busy}, 32'd0);
    end
    check("ignored_start_sb_empty", sb_q.size(), 32'd0);

    // Reset in the data strobe of a write.
    @(negedge clk);
    rw = 1'b0; addr = REG_DATE; wdata = 8'h5C; start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      start = 1'b0;
      reset = (k == 16);
      if (k == 17) begin
        check("reset_mid {cs,rd,wr,aod,oe,busy,done}",
              {25'd0, cs_n, rd_n, wr_n, aod, dut.bus_oe_r, busy, done}, 32'h0000_0078);
      end
      if (k > 17) check($sformatf("reset_mid_idle c%0d", k), {31'd0, busy}, 32'd0);
    end
    check("reset_mid_rdata", {24'd0, rdata}, 32'd0);

    // Start held high: back-to-back reads, relaunch one IDLE cycle after DONE.
    @(negedge clk);
    rw = 1'b1; addr = REG_ANO; rtc_val = 8'h77; start = 1'b1;
    sb_q.push_back('{rdata: 8'h77, valid: 1'b1});
    sb_q.push_back('{rdata: 8'h77, valid: 1'b1});
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 23) start = 1'b0;
      if (k == 21 || k == 43) check($sformatf("held_done c%0d", k), {31'd0, done}, 32'd1);
      if (k == 22) check("held_idle_gap busy", {31'd0, busy}, 32'd0);
      if (k == 23) check("held_relaunch {aod,busy}", {30'd0, aod, busy}, 32'd1);
      if (k == 44) check("held_rdata", {24'd0, rdata}, 32'h77);
    end
    check("held_sb_empty", sb_q.size(), 32'd0);

    // Minimum timing on the second instance.
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      logic [6:0] e;
      @(negedge clk);
      start1 = 1'b0;
      e = {(k <= 3 || (k >= 5 && k <= 7)) ? 1'b0 : 1'b1, 1'b1,
           (k == 2 || k == 6) ? 1'b0 : 1'b1, (k <= 3) ? 1'b0 : 1'b1,
           (k <= 8), (k == 8), 1'b0};
      check($sformatf("min_timing c%0d {cs,rd,wr,aod,busy,done,valid}", k),
            {25'd0, cs1_n, rd1_n, wr1_n, aod1, busy1, done1, rdata_valid1}, {25'd0, e});
      if (k == 2) check("min_timing_bus_addr", {24'd0, data_address1}, 32'h42);
      if (k == 6) check("min_timing_bus_data", {24'd0, data_address1}, 32'h9C);
    end
    check("min_timing_rdata", {24'd0, rdata1}, 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
